encoder_top: RTL and testbench

Registered bank of six independent binary encoders: a plain 8-to-3 encoder, two plain 4-to-2 encoders (case-style and if/else-style), two priority 4-to-2 encoders (case-style and if/else-style), and a priority 8-to-3 encoder. It is an encoder demonstration and reference block. The paired case/if-else variants act as self-checking twins: their outputs must match bit-for-bit on every cycle. All outputs are registered with a one-cycle latency and are cleared by an asynchronous active-low reset.

---
 rtl/encoder_top.sv | 112 +++++++++++
 tb/tb_encoder_top.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/encoder_top.sv
// encoder_top: registered bank of six independent binary encoders.
// The plain and priority 4-to-2 encoders each come in two twins
// (case-style and if/else-style) whose outputs must always agree.
// Every output is registered and cleared by the asynchronous reset.
module encoder_top (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_8_to_3,
  input  logic [3:0] in_4_to_2,
  input  logic [3:0] in_priority_4_to_2,
  input  logic [7:0] in_priority_8_to_3,
  output logic [2:0] out_8_to_3,
  output logic [1:0] out_4_to_2_case,
  output logic [1:0] out_4_to_2_if_else,
  output logic [1:0] out_priority_4_to_2_case,
  output logic [1:0] out_priority_4_to_2_if_else,
  output logic [2:0] out_priority_8_to_3
);

  logic [2:0] enc_8_to_3;
  logic [1:0] enc_4_to_2_case;
  logic [1:0] enc_4_to_2_if_else;
  logic [1:0] enc_priority_4_to_2_case;
  logic [1:0] enc_priority_4_to_2_if_else;
  logic [2:0] enc_priority_8_to_3;

  // Plain 8-to-3: only an exactly one-hot input yields a nonzero index
  always_comb begin
    enc_8_to_3 = 3'd0;
    case (in_8_to_3)
      8'h01:   enc_8_to_3 = 3'd0;
      8'h02:   enc_8_to_3 = 3'd1;
      8'h04:   enc_8_to_3 = 3'd2;
      8'h08:   enc_8_to_3 = 3'd3;
      8'h10:   enc_8_to_3 = 3'd4;
      8'h20:   enc_8_to_3 = 3'd5;
      8'h40:   enc_8_to_3 = 3'd6;
      8'h80:   enc_8_to_3 = 3'd7;
      default: enc_8_to_3 = 3'd0;
    endcase
  end

  // Plain 4-to-2, case twin: full case, anything non-one-hot maps to 0
  always_comb begin
    enc_4_to_2_case = 2'd0;
    case (in_4_to_2)
      4'b0001: enc_4_to_2_case = 2'd0;
      4'b0010: enc_4_to_2_case = 2'd1;
      4'b0100: enc_4_to_2_case = 2'd2;
      4'b1000: enc_4_to_2_case = 2'd3;
      default: enc_4_to_2_case = 2'd0;
    endcase
  end

  // Plain 4-to-2, if/else twin: equality-compare chain
  always_comb begin
    enc_4_to_2_if_else = 2'd0;
    if (in_4_to_2 == 4'b0001)      enc_4_to_2_if_else = 2'd0;
    else if (in_4_to_2 == 4'b0010) enc_4_to_2_if_else = 2'd1;
    else if (in_4_to_2 == 4'b0100) enc_4_to_2_if_else = 2'd2;
    else if (in_4_to_2 == 4'b1000) enc_4_to_2_if_else = 2'd3;
    else                           enc_4_to_2_if_else = 2'd0;
  end

  // Priority 4-to-2, case twin: wildcard match, bit 3 wins
  always_comb begin
    enc_priority_4_to_2_case = 2'd0;
    casez (in_priority_4_to_2)
      4'b1???: enc_priority_4_to_2_case = 2'd3;
      4'b01??: enc_priority_4_to_2_case = 2'd2;
      4'b001?: enc_priority_4_to_2_case = 2'd1;
      default: enc_priority_4_to_2_case = 2'd0;
    endcase
  end

  // Priority 4-to-2, if/else twin: test bit 3 first, down to bit 0
  always_comb begin
    enc_priority_4_to_2_if_else = 2'd0;
    if (in_priority_4_to_2[3])      enc_priority_4_to_2_if_else = 2'd3;
    else if (in_priority_4_to_2[2]) enc_priority_4_to_2_if_else = 2'd2;
    else if (in_priority_4_to_2[1]) enc_priority_4_to_2_if_else = 2'd1;
    else                            enc_priority_4_to_2_if_else = 2'd0;
  end

  // Priority 8-to-3: ascending scan so the highest set bit is written last
  always_comb begin
    enc_priority_8_to_3 = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (in_priority_8_to_3[i]) enc_priority_8_to_3 = 3'(i);
    end
  end

  // Output registers: one-cycle latency, cleared immediately by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_8_to_3                  <= 3'd0;
      out_4_to_2_case             <= 2'd0;
      out_4_to_2_if_else          <= 2'd0;
      out_priority_4_to_2_case    <= 2'd0;
      out_priority_4_to_2_if_else <= 2'd0;
      out_priority_8_to_3         <= 3'd0;
    end else begin
      out_8_to_3                  <= enc_8_to_3;
      out_4_to_2_case             <= enc_4_to_2_case;
      out_4_to_2_if_else          <= enc_4_to_2_if_else;
      out_priority_4_to_2_case    <= enc_priority_4_to_2_case;
      out_priority_4_to_2_if_else <= enc_priority_4_to_2_if_else;
      out_priority_8_to_3         <= enc_priority_8_to_3;
    end
  end

endmodule

// File: tb/tb_encoder_top.sv
// tb_encoder_top: directed checks of the encoder bank, a 4-bit sweep and
// a random 8-bit sweep against a small behavioural model.
module tb_encoder_top;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_8_to_3;
  logic [3:0] in_4_to_2;
  logic [3:0] in_priority_4_to_2;
  logic [7:0] in_priority_8_to_3;
  logic [2:0] out_8_to_3;
  logic [1:0] out_4_to_2_case;
  logic [1:0] out_4_to_2_if_else;
  logic [1:0] out_priority_4_to_2_case;
  logic [1:0] out_priority_4_to_2_if_else;
  logic [2:0] out_priority_8_to_3;

  int total = 0;
  int bad   = 0;

  encoder_top dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .in_8_to_3                   (in_8_to_3),
    .in_4_to_2                   (in_4_to_2),
    .in_priority_4_to_2          (in_priority_4_to_2),
    .in_priority_8_to_3          (in_priority_8_to_3),
    .out_8_to_3                  (out_8_to_3),
    .out_4_to_2_case             (out_4_to_2_case),
    .out_4_to_2_if_else          (out_4_to_2_if_else),
    .out_priority_4_to_2_case    (out_priority_4_to_2_case),
    .out_priority_4_to_2_if_else (out_priority_4_to_2_if_else),
    .out_priority_8_to_3         (out_priority_8_to_3)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: index of the single set bit, 0 unless exactly one bit is set
  function automatic logic [2:0] plainModel(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    if ($countones(v) == 1) begin
      for (int k = 0; k < 8; k++) if (v[k]) r = 3'(k);
    end
    return r;
  endfunction

  // Model: index of the most-significant set bit, 0 for zero input
  function automatic logic [2:0] priorityModel(input logic [7:0] v);
    for (int k = 7; k >= 0; k--) if (v[k]) return 3'(k);
    return 3'd0;
  endfunction

  task automatic checkOne(input string tag, input string name,
                          input logic [2:0] got, input logic [2:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s %s: got %0d expected %0d", tag, name, got, exp);
    end
  endtask

  // Compare all six outputs; both twins of a pair share one expectation
  task automatic checkOutput(input string tag, input logic [2:0] e83,
                             input logic [1:0] e42, input logic [1:0] ep42,
                             input logic [2:0] ep83);
    checkOne(tag, "out_8_to_3", out_8_to_3, e83);
    checkOne(tag, "out_4_to_2_case", {1'b0, out_4_to_2_case}, {1'b0, e42});
    checkOne(tag, "out_4_to_2_if_else", {1'b0, out_4_to_2_if_else}, {1'b0, e42});
    checkOne(tag, "out_pri_4_to_2_case", {1'b0, out_priority_4_to_2_case}, {1'b0, ep42});
    checkOne(tag, "out_pri_4_to_2_if_else", {1'b0, out_priority_4_to_2_if_else}, {1'b0, ep42});
    checkOne(tag, "out_pri_8_to_3", out_priority_8_to_3, ep83);
  endtask

  // Drive one input set, let one rising edge capture it, sample 1 unit later
  task automatic applyStimulus(input logic [7:0] v83, input logic [3:0] v42,
                               input logic [3:0] vp42, input logic [7:0] vp83);
    in_8_to_3          = v83;
    in_4_to_2          = v42;
    in_priority_4_to_2 = vp42;
    in_priority_8_to_3 = vp83;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] multi_vec [4];
  logic [1:0] multi_pri [4];
  logic [7:0] p8_vec [4];
  logic [2:0] p8_exp [4];
  logic [2:0] p8_plain [4];
  logic [7:0] r8a;
  logic [7:0] r8b;
  logic [3:0] v4;

  initial begin
    multi_vec = '{4'b0011, 4'b0110, 4'b1100, 4'b1111};
    multi_pri = '{2'd1, 2'd2, 2'd3, 2'd3};
    p8_vec    = '{8'h10, 8'h3F, 8'h81, 8'h00};
    p8_exp    = '{3'd4, 3'd5, 3'd7, 3'd0};
    p8_plain  = '{3'd4, 3'd0, 3'd0, 3'd0};

    // Reset with all inputs high: outputs zero before any clock edge
    rst_n              = 1'b0;
    in_8_to_3          = 8'hFF;
    in_4_to_2          = 4'hF;
    in_priority_4_to_2 = 4'hF;
    in_priority_8_to_3 = 8'hFF;
    #2;
    checkOutput("reset_async", 3'd0, 2'd0, 2'd0, 3'd0);
    #5;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_release", 3'd0, 2'd0, 2'd3, 3'd7);

    // One-hot walk; the 4-bit inputs go back to zero after four steps
    for (int i = 0; i < 8; i++) begin
      applyStimulus(8'(1 << i), (i < 4) ? 4'(1 << i) : 4'd0,
                    (i < 4) ? 4'(1 << i) : 4'd0, 8'(1 << i));
      checkOutput($sformatf("walk_%0d", i), 3'(i), (i < 4) ? 2'(i) : 2'd0,
                  (i < 4) ? 2'(i) : 2'd0, 3'(i));
    end

    // Multi-bit 4-bit vectors alongside the priority 8-to-3 directed set
    for (int i = 0; i < 4; i++) begin
      applyStimulus(p8_vec[i], multi_vec[i], multi_vec[i], p8_vec[i]);
      checkOutput($sformatf("multi_%0d", i), p8_plain[i], 2'd0,
                  multi_pri[i], p8_exp[i]);
    end

    // Latency: an input changed mid-cycle is not visible before the edge
    applyStimulus(8'h04, 4'b0010, 4'b0100, 8'h20);
    in_8_to_3          = 8'h80;
    in_priority_8_to_3 = 8'h01;
    #3;
    checkOutput("hold_between_edges", 3'd2, 2'd1, 2'd2, 3'd5);
    @(posedge clk);
    #1;
    checkOutput("after_next_edge", 3'd7, 2'd1, 2'd2, 3'd0);

    // Exhaustive 4-bit sweep and random 8-bit sweep against the model
    for (int i = 0; i < 16; i++) begin
      v4  = 4'(i);
      r8a = 8'($urandom_range(0, 255));
      r8b = 8'($urandom_range(0, 255));
      applyStimulus(r8a, v4, v4, r8b);
      checkOutput($sformatf("sweep_%0d", i), plainModel(r8a),
                  2'(plainModel({4'd0, v4})), 2'(priorityModel({4'd0, v4})),
                  priorityModel(r8b));
    end

    // Mid-stream reset between edges, then recovery on the next edge
    applyStimulus(8'h40, 4'b1000, 4'b0101, 8'h0C);
    checkOutput("pre_midreset", 3'd6, 2'd3, 2'd2, 3'd3);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_async", 3'd0, 2'd0, 2'd0, 3'd0);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("midreset_released_no_edge", 3'd0, 2'd0, 2'd0, 3'd0);
    @(posedge clk);
    #1;
    checkOutput("midreset_recover", 3'd6, 2'd3, 2'd2, 3'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
